// File: rtl/k423_bpu_pkg.sv
// Shared types and constants for the k423 branch prediction unit.
// Holds the RAS operation encoding, checkpoint layout and call/ret decode helper.
package k423_bpu_pkg;

    localparam int CORE_XLEN = 32;
    localparam int RAS_DEPTH = 8;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        RAS_NONE    = 2'd0,
        RAS_PUSH    = 2'd1,
        RAS_POP     = 2'd2,
        RAS_POPPUSH = 2'd3
    } ras_op_e;

    typedef struct packed {
        logic [RAS_PTR_W-1:0] ptr;
        logic [RAS_CNT_W-1:0] cnt;
        logic [CORE_XLEN-1:0] top;
    } ras_ckpt_t;

    // Mini-decoder flags to stack operation; call+ret is a co-routine swap.
    function automatic ras_op_e ras_decode(input logic call, input logic ret);
        ras_op_e op;
        case ({call, ret})
            2'b10:   op = RAS_PUSH;
            2'b01:   op = RAS_POP;
            2'b11:   op = RAS_POPPUSH;
            default: op = RAS_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/k423_bpu_ras.sv
// Return-address stack for the IF-stage branch predictor (circular buffer, saturating count).
// Optional checkpoint restore on misprediction is enabled by defining K423_RAS_RECOVER_EN.
module k423_bpu_ras
    import k423_bpu_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req_vld_i,
    input  logic [CORE_XLEN-1:0] pc_i,
    input  logic                 dec_call_i,
    input  logic                 dec_ret_i,
    output logic                 pred_vld_o,
    output logic [CORE_XLEN-1:0] pred_addr_o,
    output logic [PTR_W-1:0]     ckpt_ptr_o,
    output logic [CNT_W-1:0]     ckpt_cnt_o,
    input  logic                 rec_vld_i,
    input  logic [PTR_W-1:0]     rec_ptr_i,
    input  logic [CNT_W-1:0]     rec_cnt_i,
    input  logic [CORE_XLEN-1:0] rec_top_i
);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [CORE_XLEN-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]     ptr_r;
    logic [CNT_W-1:0]     cnt_r;

    ras_op_e              op_s;
    logic [CORE_XLEN-1:0] ret_addr_s;
    logic [PTR_W-1:0]     ptr_nxt_s;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic                 wr_en_s;
    logic [PTR_W-1:0]     wr_idx_s;
    logic [CORE_XLEN-1:0] wr_data_s;

    assign ret_addr_s = pc_i + CORE_XLEN'(32'd4);

    // Decode the fetched instruction; recovery squashes the IF request.
    always_comb begin
        if (req_vld_i && !rec_vld_i) begin
            op_s = ras_decode(dec_call_i, dec_ret_i);
        end else begin
            op_s = RAS_NONE;
        end
    end

`ifdef K423_RAS_RECOVER_EN
    logic [CNT_W-1:0] rec_cnt_clamp_s;

    // Checkpointed occupancy beyond the stack size is meaningless; clamp it.
    always_comb begin
        if (rec_cnt_i > CNT_DEPTH) begin
            rec_cnt_clamp_s = CNT_DEPTH;
        end else begin
            rec_cnt_clamp_s = rec_cnt_i;
        end
    end
`else
    logic rec_unused_s;
    assign rec_unused_s = ^{rec_ptr_i, rec_cnt_i, rec_top_i};
`endif

    // Next pointer/count and the single entry write for this cycle.
    always_comb begin
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
        wr_en_s   = 1'b0;
        wr_idx_s  = ptr_r;
        wr_data_s = ret_addr_s;
        if (rec_vld_i) begin
`ifdef K423_RAS_RECOVER_EN
            ptr_nxt_s = rec_ptr_i;
            cnt_nxt_s = rec_cnt_clamp_s;
            wr_en_s   = 1'b1;
            wr_idx_s  = rec_ptr_i;
            wr_data_s = rec_top_i;
`else
            ptr_nxt_s = '0;
            cnt_nxt_s = '0;
`endif
        end else begin
            case (op_s)
                RAS_PUSH: begin
                    ptr_nxt_s = ptr_r + PTR_ONE;
                    wr_en_s   = 1'b1;
                    wr_idx_s  = ptr_r + PTR_ONE;
                    if (cnt_r == CNT_DEPTH) begin
                        cnt_nxt_s = cnt_r;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                RAS_POP: begin
                    if (cnt_r != '0) begin
                        ptr_nxt_s = ptr_r - PTR_ONE;
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end else begin
                        ptr_nxt_s = ptr_r;
                        cnt_nxt_s = cnt_r;
                    end
                end
                RAS_POPPUSH: begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = ptr_r;
                    if (cnt_r == '0) begin
                        cnt_nxt_s = CNT_ONE;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                default: begin
                    ptr_nxt_s = ptr_r;
                    cnt_nxt_s = cnt_r;
                end
            endcase
        end
    end

    // Top-of-stack pointer and occupancy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_r <= '0;
            cnt_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    // Entry array; a full stack silently overwrites its oldest slot.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

    assign pred_addr_o = mem_r[ptr_r];
    assign pred_vld_o  = (cnt_r != '0);

`ifdef K423_RAS_RECOVER_EN
    assign ckpt_ptr_o = ptr_r;
    assign ckpt_cnt_o = cnt_r;
`else
    assign ckpt_ptr_o = '0;
    assign ckpt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_k423_bpu_ras.sv
// Scoreboard bench for k423_bpu_ras: directed vectors push expected outputs,
// a negedge monitor pops and compares them. Covers both K423_RAS_RECOVER_EN builds.
module tb_k423_bpu_ras;

    typedef struct {
        logic        vld;
        logic [31:0] addr;
        logic [2:0]  ptr;
        logic [3:0]  cnt;
        string       nm;
    } exp_t;

    logic        clk_s = 1'b0;
    logic        rst_n_s = 1'b0;
    logic        req_vld_s = 1'b0;
    logic [31:0] pc_s = 32'd0;
    logic        call_s = 1'b0;
    logic        ret_s = 1'b0;
    logic        pred_vld_s;
    logic [31:0] pred_addr_s;
    logic [2:0]  ckpt_ptr_s;
    logic [3:0]  ckpt_cnt_s;
    logic        rec_vld_s = 1'b0;
    logic [2:0]  rec_ptr_s = 3'd0;
    logic [3:0]  rec_cnt_s = 4'd0;
    logic [31:0] rec_top_s = 32'd0;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    k423_bpu_ras dut (
        .clk_i      (clk_s),
        .rst_n_i    (rst_n_s),
        .req_vld_i  (req_vld_s),
        .pc_i       (pc_s),
        .dec_call_i (call_s),
        .dec_ret_i  (ret_s),
        .pred_vld_o (pred_vld_s),
        .pred_addr_o(pred_addr_s),
        .ckpt_ptr_o (ckpt_ptr_s),
        .ckpt_cnt_o (ckpt_cnt_s),
        .rec_vld_i  (rec_vld_s),
        .rec_ptr_i  (rec_ptr_s),
        .rec_cnt_i  (rec_cnt_s),
        .rec_top_i  (rec_top_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic push_exp(input logic ev, input logic [31:0] ea,
                            input logic [2:0] ep, input logic [3:0] ec, input string nm);
        exp_t e;
        e.vld  = ev;
        e.addr = ea;
`ifdef K423_RAS_RECOVER_EN
        e.ptr  = ep;
        e.cnt  = ec;
`else
        e.ptr  = 3'd0;
        e.cnt  = 4'd0;
`endif
        e.nm   = nm;
        exp_q.push_back(e);
    endtask

    // One cycle: drive inputs #1 after the edge, expect the pre-update state.
    task automatic step(input logic req, input logic call, input logic ret, input logic [31:0] pc,
                        input logic rec, input logic [2:0] rptr, input logic [3:0] rcnt,
                        input logic [31:0] rtop, input logic ev, input logic [31:0] ea,
                        input logic [2:0] ep, input logic [3:0] ec, input string nm);
        @(posedge clk_s);
        #1;
        req_vld_s = req;
        call_s    = call;
        ret_s     = ret;
        pc_s      = pc;
        rec_vld_s = rec;
        rec_ptr_s = rptr;
        rec_cnt_s = rcnt;
        rec_top_s = rtop;
        push_exp(ev, ea, ep, ec, nm);
    endtask

    task automatic op(input logic call, input logic ret, input logic [31:0] pc,
                      input logic ev, input logic [31:0] ea, input logic [2:0] ep,
                      input logic [3:0] ec, input string nm);
        step(1'b1, call, ret, pc, 1'b0, 3'd0, 4'd0, 32'd0, ev, ea, ep, ec, nm);
    endtask

    // Monitor: outputs are always presented; compare whenever an expectation is pending.
    always @(negedge clk_s) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (pred_vld_s !== e.vld) begin
                miscompares++;
                $display("FAIL %s pred_vld: got %0b want %0b", e.nm, pred_vld_s, e.vld);
            end
            if (pred_addr_s !== e.addr) begin
                miscompares++;
                $display("FAIL %s pred_addr: got %h want %h", e.nm, pred_addr_s, e.addr);
            end
            if (ckpt_ptr_s !== e.ptr) begin
                miscompares++;
                $display("FAIL %s ckpt_ptr: got %0d want %0d", e.nm, ckpt_ptr_s, e.ptr);
            end
            if (ckpt_cnt_s !== e.cnt) begin
                miscompares++;
                $display("FAIL %s ckpt_cnt: got %0d want %0d", e.nm, ckpt_cnt_s, e.cnt);
            end
        end
    end

    initial begin
        int budget;
        // Reset held: outputs must be zero.
        @(posedge clk_s);
        #1;
        push_exp(1'b0, 32'h0, 3'd0, 4'd0, "reset_held");
        @(posedge clk_s);
        #1;
        rst_n_s = 1'b1;

        op(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    3'd0, 4'd0, "idle_after_reset");
        op(1'b0, 1'b1, 32'h100,  1'b0, 32'h0,    3'd0, 4'd0, "ret_on_empty");
        op(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    3'd0, 4'd0, "underflow_ignored");
        op(1'b1, 1'b0, 32'h1000, 1'b0, 32'h0,    3'd0, 4'd0, "call_1000");
        op(1'b1, 1'b0, 32'h2000, 1'b1, 32'h1004, 3'd1, 4'd1, "call_2000");
        op(1'b0, 1'b1, 32'h0,    1'b1, 32'h2004, 3'd2, 4'd2, "ret_predicts_2004");
        step(1'b0, 1'b1, 1'b0, 32'hDEAD0, 1'b0, 3'd0, 4'd0, 32'd0,
             1'b1, 32'h1004, 3'd1, 4'd1, "after_ret_1004");
        op(1'b1, 1'b0, 32'h100,  1'b1, 32'h1004, 3'd1, 4'd1, "req_low_call_dropped");
        op(1'b1, 1'b1, 32'h300,  1'b1, 32'h104,  3'd2, 4'd2, "poppush_pre");
        op(1'b0, 1'b0, 32'h0,    1'b1, 32'h304,  3'd2, 4'd2, "poppush_top_304");
        op(1'b0, 1'b1, 32'h0,    1'b1, 32'h304,  3'd2, 4'd2, "drain_ret_a");
        op(1'b0, 1'b1, 32'h0,    1'b1, 32'h1004, 3'd1, 4'd1, "drain_ret_b");
        op(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    3'd0, 4'd0, "drained_empty");
        op(1'b1, 1'b1, 32'h500,  1'b0, 32'h0,    3'd0, 4'd0, "poppush_on_empty");
        op(1'b0, 1'b1, 32'h0,    1'b1, 32'h504,  3'd0, 4'd1, "poppush_sets_cnt1");
        op(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    3'd7, 4'd0, "ptr_wrapped_down");

        // Nine calls at 0x10*k, starting from ptr 7 / cnt 0.
        for (int k = 1; k <= 9; k++) begin
            op(1'b1, 1'b0, 32'(k * 16), (k > 1), (k > 1) ? 32'((k - 1) * 16 + 4) : 32'h0,
               3'((6 + k) % 8), 4'(k - 1), "call_fill");
        end
        op(1'b0, 1'b0, 32'h0, 1'b1, 32'h94, 3'd0, 4'd8, "full_saturated");
        for (int j = 0; j < 8; j++) begin
            op(1'b0, 1'b1, 32'h0, 1'b1, 32'(32'h94 - j * 16), 3'((8 - j) % 8), 4'(8 - j), "ret_drain");
        end
        op(1'b0, 1'b0, 32'h0, 1'b0, 32'h94, 3'd0, 4'd0, "empty_after_8_rets");
        op(1'b0, 1'b1, 32'h0, 1'b0, 32'h94, 3'd0, 4'd0, "extra_ret");
        op(1'b1, 1'b0, 32'h40, 1'b0, 32'h94, 3'd0, 4'd0, "extra_ret_ignored");

        // Reset asserted mid-operation wipes the call just made.
        @(posedge clk_s);
        #1;
        req_vld_s = 1'b0;
        call_s    = 1'b0;
        rst_n_s   = 1'b0;
        push_exp(1'b0, 32'h0, 3'd0, 4'd0, "midop_reset");
        @(posedge clk_s);
        #1;
        rst_n_s = 1'b1;
        push_exp(1'b0, 32'h0, 3'd0, 4'd0, "after_midop_reset");

        op(1'b1, 1'b1, 32'h700,  1'b0, 32'h0,    3'd0, 4'd0, "ck_poppush");
        op(1'b1, 1'b0, 32'h1000, 1'b1, 32'h704,  3'd0, 4'd1, "ck_call");
        op(1'b0, 1'b0, 32'h0,    1'b1, 32'h1004, 3'd1, 4'd2, "ck_record");
        op(1'b1, 1'b0, 32'h3000, 1'b1, 32'h1004, 3'd1, 4'd2, "spurious_1");
        op(1'b1, 1'b0, 32'h3100, 1'b1, 32'h3004, 3'd2, 4'd3, "spurious_2");
        op(1'b1, 1'b0, 32'h3200, 1'b1, 32'h3104, 3'd3, 4'd4, "spurious_3");
        step(1'b1, 1'b1, 1'b0, 32'h4000, 1'b1, 3'd1, 4'd2, 32'h1004,
             1'b1, 32'h3204, 3'd4, 4'd5, "rec_with_call");
`ifdef K423_RAS_RECOVER_EN
        op(1'b0, 1'b0, 32'h0, 1'b1, 32'h1004, 3'd1, 4'd2, "restored");
        op(1'b0, 1'b1, 32'h0, 1'b1, 32'h1004, 3'd1, 4'd2, "restored_ret");
        op(1'b0, 1'b0, 32'h0, 1'b1, 32'h704,  3'd0, 4'd1, "restored_below");
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd3, 4'd15, 32'hABC,
             1'b1, 32'h704, 3'd0, 4'd1, "rec_clamp");
        op(1'b0, 1'b0, 32'h0, 1'b1, 32'hABC, 3'd3, 4'd8, "clamped_cnt8");
`else
        op(1'b0, 1'b0, 32'h0,   1'b0, 32'h704, 3'd0, 4'd0, "rec_emptied");
        op(1'b1, 1'b0, 32'h800, 1'b0, 32'h704, 3'd0, 4'd0, "call_after_empty");
        op(1'b0, 1'b0, 32'h0,   1'b1, 32'h804, 3'd1, 4'd1, "top_804");
        op(1'b0, 1'b1, 32'h0,   1'b1, 32'h804, 3'd1, 4'd1, "ret_804");
        op(1'b0, 1'b0, 32'h0,   1'b0, 32'h704, 3'd0, 4'd0, "entries_untouched");
`endif
        @(posedge clk_s);
        #1;
        req_vld_s = 1'b0;
        call_s    = 1'b0;
        ret_s     = 1'b0;
        rec_vld_s = 1'b0;

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk_s);
            budget++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/k423_bpu_ras.md
# k423_bpu_ras

Return-address stack (RAS) for the branch prediction unit in the IF stage. It consumes the mini-decoder's `call`/`ret` flags for each fetched instruction. It pushes the return address on calls and predicts the target of returns from the stack top. It restores its state from a checkpoint when EX resolves a misprediction.

## Interface
Parameters:
- `DEPTH`, 8: number of stack entries; power of two, >= 2.
- `PTR_W`, $clog2(DEPTH): width of the top-of-stack pointer.
- `CNT_W`, $clog2(DEPTH+1): width of the occupancy count.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: core clock.
- `rst_n_i` in 1: asynchronous active-low reset.
- `req_vld_i` in 1: the IF-stage instruction at `pc_i` is accepted this cycle; the stack updates only when this is high.
- `pc_i` in `CORE_XLEN`: PC of that instruction.
- `dec_call_i` in 1: call flag from the mini-decoder.
- `dec_ret_i` in 1: return flag from the mini-decoder.
- `pred_vld_o` out 1: stack is non-empty, so `pred_addr_o` is usable.
- `pred_addr_o` out `CORE_XLEN`: current top-of-stack entry.
- `ckpt_ptr_o` out `PTR_W`: current pointer, carried down the pipe with the prediction.
- `ckpt_cnt_o` out `CNT_W`: current occupancy, carried down the pipe with the prediction.
- `rec_vld_i` in 1: misprediction recovery request from EX.
- `rec_ptr_i` in `PTR_W`: checkpointed pointer.
- `rec_cnt_i` in `CNT_W`: checkpointed occupancy.
- `rec_top_i` in `CORE_XLEN`: checkpointed top entry.

## Operation
- Storage is `DEPTH` × `CORE_XLEN` flops in a circular buffer. `ptr` indexes the top entry. `cnt` is occupancy and saturates at `DEPTH`.
- The return address is `pc_i + 4`. Only RV32 encodings raise the call/ret flags, so there is no compressed case.
- Action is taken only when `req_vld_i` = 1 and `rec_vld_i` = 0:
  - call only (PUSH): `ptr <= ptr+1` (mod `DEPTH`); `mem[ptr+1] <= pc_i+4`; `cnt <= min(cnt+1, DEPTH)`. When full, the oldest entry is overwritten silently.
  - ret only (POP): if `cnt` != 0, `ptr <= ptr-1` (mod `DEPTH`) and `cnt <= cnt-1`. If `cnt` = 0, nothing changes (underflow is ignored).
  - call and ret together (co-routine JALR, pop-then-push): `mem[ptr] <= pc_i+4`; `ptr` unchanged; `cnt <= max(cnt,1)`.
  - neither: hold.
- Recovery takes priority: when `rec_vld_i` = 1, the request from `req_vld_i` is ignored that cycle. Recovery behaviour is set by the configuration macro below.
- Outputs:
  - `pred_addr_o = mem[ptr]`.
  - `pred_vld_o = (cnt != 0)`.
  - `ckpt_ptr_o = ptr`.
  - `ckpt_cnt_o = cnt`.
- Arithmetic:
  - Pointer increment and decrement wrap modulo `DEPTH` naturally in `PTR_W` bits.
  - `pc_i+4` is truncated to `CORE_XLEN`.
- `rec_cnt_i` > `DEPTH` is clamped to `DEPTH`.

## Timing
- Reset (asynchronous, active-low):
  - `ptr` = 0, `cnt` = 0, all entries = 0.
  - Outputs: `pred_vld_o` = 0, `pred_addr_o` = 0, `ckpt_ptr_o` = 0, `ckpt_cnt_o` = 0.
  - Reset asserted mid-operation discards all state immediately.
- Read latency is 0: outputs are combinational from registers and reflect the state before this cycle's update. A ret in cycle N is predicted from the state as it stood at the start of cycle N.
- An update in cycle N is visible on the outputs in cycle N+1. Back-to-back call/ret on consecutive cycles is supported at full rate.
- Recovery in cycle N: the restored state is visible in cycle N+1. An IF request in cycle N is dropped; IF is flushed in the same cycle by the pipeline.

## Configuration
- `K423_RAS_RECOVER_EN` defined:
  - `rec_vld_i` loads `ptr <= rec_ptr_i`, `cnt <= rec_cnt_i` (clamped to `DEPTH`), and `mem[rec_ptr_i] <= rec_top_i`.
  - Checkpoint outputs are live.
- Not defined:
  - `rec_vld_i` empties the stack: `ptr` <= 0, `cnt` <= 0; entries are untouched.
  - `rec_ptr_i`, `rec_cnt_i` and `rec_top_i` are ignored.
  - `ckpt_ptr_o` and `ckpt_cnt_o` are tied to 0.

## Structure
- Shared package `k423_bpu_pkg`:
  - `ras_ckpt_t` packed struct {ptr, cnt, top}.
  - Localparam `RAS_DEPTH` = 8.
  - `ras_op_e` enum {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH}.
- No sub-module. The next-state logic is a single `ras_op_e` decode followed by one always_ff for `ptr`/`cnt` and one for the entry array.

## Test plan
- Reset then idle: all outputs 0; a ret with pc 0x100 leaves `cnt` = 0 and `pred_vld_o` = 0.
- Calls at 0x1000 then 0x2000, then ret: `pred_addr_o` is 0x2004 during the ret cycle. After the ret, `pred_addr_o` = 0x1004 and `cnt` = 1.
- 9 calls at pc 0x10·k (k=1..9) with `DEPTH` = 8:
  - `cnt` saturates at 8 and top = 0x94.
  - 8 rets yield 0x94 down to 0x24; then `pred_vld_o` = 0.
- Call+ret together at 0x300 with `cnt` = 2 and top 0x104: top becomes 0x304, `cnt` stays 2, `ptr` unchanged.
- Recovery (macro on):
  - Record checkpoint `ptr` = 1, `cnt` = 2, top = 0x1004, then do 3 spurious calls.
  - Assert `rec_vld_i` together with a call: the state returns to `ptr` = 1, `cnt` = 2, `pred_addr_o` = 0x1004, and the call is dropped.
- Macro off: `rec_vld_i` with `cnt` = 5 gives `cnt` = 0 and `pred_vld_o` = 0 in the next cycle; `ckpt_*` read 0 throughout.
